// File: rtl/tlight_pkg.sv
// tlight_pkg: shared state/road encodings, default dwell times and lamp decode for the junction sequencer
package tlight_pkg;
  typedef enum logic [3:0] {
    NS_RA = 4'd0,
    NS_G  = 4'd1,
    NS_A  = 4'd2,
    CLR_A = 4'd3,
    EW_RA = 4'd4,
    EW_G  = 4'd5,
    EW_A  = 4'd6,
    CLR_B = 4'd7,
    WALK  = 4'd8,
    CLR_W = 4'd9
  } state_t;
  typedef enum logic {NS = 1'b0, EW = 1'b1} road_t;
  typedef struct packed {
    logic ns_r;
    logic ns_a;
    logic ns_g;
    logic ew_r;
    logic ew_a;
    logic ew_g;
    logic walk;
  } lamps_t;
  localparam int CNT_W_DEF = 8;
  localparam int GREEN_DEF = 8;
  localparam int AMBER_DEF = 3;
  localparam int RA_DEF    = 2;
  localparam int CLR_DEF   = 2;
  localparam int WALK_DEF  = 5;
  function automatic lamps_t lamps_of(state_t s);
    lamps_t l;
    l = 7'b1001000;
    case (s)
      NS_RA:   l = 7'b1101000;
      NS_G:    l = 7'b0011000;
      NS_A:    l = 7'b0101000;
      EW_RA:   l = 7'b1001100;
      EW_G:    l = 7'b1000010;
      EW_A:    l = 7'b1000100;
      WALK:    l = 7'b1001001;
      default: l = 7'b1001000;
    endcase
    return l;
  endfunction
endpackage

// File: rtl/junction_ctrl_if.sv
// junction_ctrl_if: pedestrian request in, lamp drives and debug phase out
interface junction_ctrl_if;
  logic       ped_req;
  logic       ns_r, ns_a, ns_g;
  logic       ew_r, ew_a, ew_g;
  logic       walk;
  logic       ped_wait;
  logic [3:0] phase;
  modport slave (input ped_req, output ns_r, ns_a, ns_g, ew_r, ew_a, ew_g, walk, ped_wait, phase);
  modport master (output ped_req, input ns_r, ns_a, ns_g, ew_r, ew_a, ew_g, walk, ped_wait, phase);
endinterface

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter flagging the last cycle of a phase
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);
  logic [CNT_W-1:0] count_q, count_d;
  // reload has priority over counting down
  always_comb count_d = load ? load_val : en ? count_q - CNT_W'(1) : count_q;
  // counter register; reset arrives as a load from the controller
  always_ff @(posedge clk) count_q <= count_d;
  assign done = count_q == '0;
endmodule

// File: rtl/junction_ctrl.sv
// junction_ctrl: timed two-road UK light sequencer with all-red clearance and pedestrian WALK insertion
module junction_ctrl
  import tlight_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GREEN_CYC = GREEN_DEF,
  parameter int AMBER_CYC = AMBER_DEF,
  parameter int RA_CYC    = RA_DEF,
  parameter int CLR_CYC   = CLR_DEF,
  parameter int WALK_CYC  = WALK_DEF
) (
  input logic           clk,
  input logic           rst,
  junction_ctrl_if.slave bus
);
  localparam int MAXD = 1 << CNT_W;
  if (GREEN_CYC < 1 || GREEN_CYC > MAXD || AMBER_CYC < 1 || AMBER_CYC > MAXD ||
      RA_CYC < 1 || RA_CYC > MAXD || CLR_CYC < 1 || CLR_CYC > MAXD ||
      WALK_CYC < 1 || WALK_CYC > MAXD) begin : g_bad_dwell
    $error("junction_ctrl: dwell parameter outside 1..2**CNT_W");
  end
  localparam logic [CNT_W-1:0] G_L = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] A_L = CNT_W'(AMBER_CYC - 1);
  localparam logic [CNT_W-1:0] R_L = CNT_W'(RA_CYC - 1);
  localparam logic [CNT_W-1:0] C_L = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] W_L = CNT_W'(WALK_CYC - 1);
  logic [3:0]       state_q, state_d, nxt;
  logic             pending_q, pending_d;
  road_t            next_road_q, next_road_d;
  logic             done, illegal, take_walk, load;
  logic [CNT_W-1:0] load_val;
  lamps_t           lamps;
  function automatic logic [CNT_W-1:0] dwell_m1(input logic [3:0] s);
    return (s == NS_G || s == EW_G) ? G_L :
           (s == NS_A || s == EW_A) ? A_L :
           (s == NS_RA || s == EW_RA) ? R_L :
           (s == WALK) ? W_L : C_L;
  endfunction
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .load(load), .load_val(load_val), .en(!done), .done(done)
  );
  // successor state, pedestrian insertion and timer reload
  always_comb begin
    illegal   = state_q > CLR_W;
    take_walk = (state_q == CLR_A || state_q == CLR_B) && (pending_q || bus.ped_req);
    nxt = CLR_B;
    case (state_q)
      NS_RA:   nxt = NS_G;
      NS_G:    nxt = NS_A;
      NS_A:    nxt = CLR_A;
      CLR_A:   nxt = take_walk ? WALK : EW_RA;
      EW_RA:   nxt = EW_G;
      EW_G:    nxt = EW_A;
      EW_A:    nxt = CLR_B;
      CLR_B:   nxt = take_walk ? WALK : NS_RA;
      WALK:    nxt = CLR_W;
      CLR_W:   nxt = next_road_q == NS ? NS_RA : EW_RA;
      default: nxt = CLR_B;
    endcase
    state_d     = illegal ? CLR_B : done ? nxt : state_q;
    pending_d   = (done && take_walk) ? 1'b0 : pending_q | (bus.ped_req && state_q != WALK);
    next_road_d = (done && take_walk) ? (state_q == CLR_A ? EW : NS) : next_road_q;
    load        = rst || illegal || done;
    load_val    = (rst || illegal) ? C_L : dwell_m1(nxt);
  end
  // state, request latch and resume road
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLR_B;
      pending_q   <= 1'b0;
      next_road_q <= NS;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      next_road_q <= next_road_d;
    end
  end
  assign lamps        = lamps_of(state_t'(state_q));
  assign bus.ns_r     = lamps.ns_r;
  assign bus.ns_a     = lamps.ns_a;
  assign bus.ns_g     = lamps.ns_g;
  assign bus.ew_r     = lamps.ew_r;
  assign bus.ew_a     = lamps.ew_a;
  assign bus.ew_g     = lamps.ew_g;
  assign bus.walk     = lamps.walk;
  assign bus.ped_wait = pending_q;
  assign bus.phase    = state_q;
endmodule

// File: tb/tb_junction_ctrl.sv
// tb_junction_ctrl: directed phase/lamp/ped_wait checks on default and all-ones dwell junctions
module tb_junction_ctrl;
  import tlight_pkg::*;
  typedef struct {
    logic [3:0] ph;
    int         pw;
  } step_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_f = 1'b1;
  int total = 0;
  int bad = 0;
  step_t q[$];
  logic [3:0] ord [8];
  junction_ctrl_if bus ();
  junction_ctrl_if fbus ();
  junction_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  junction_ctrl #(.CNT_W(8), .GREEN_CYC(1), .AMBER_CYC(1), .RA_CYC(1), .CLR_CYC(1), .WALK_CYC(1))
    fdut (.clk(clk), .rst(rst_f), .bus(fbus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] exp_lamps(input logic [3:0] p);
    case (p)
      NS_RA:   return 7'b1101000;
      NS_G:    return 7'b0011000;
      NS_A:    return 7'b0101000;
      EW_RA:   return 7'b1001100;
      EW_G:    return 7'b1000010;
      EW_A:    return 7'b1000100;
      WALK:    return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction
  task automatic add(input logic [3:0] ph, input int n, input int pw);
    for (int i = 0; i < n; i++) q.push_back('{ph, pw});
  endtask
  task automatic add_base(input int pw);
    add(CLR_B, 2, pw); add(NS_RA, 2, pw); add(NS_G, 8, pw); add(NS_A, 3, pw);
    add(CLR_A, 2, pw); add(EW_RA, 2, pw); add(EW_G, 8, pw); add(EW_A, 3, pw);
  endtask
  task automatic follow(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      check({tag, "_phase"}, bus.phase, s.ph);
      check({tag, "_lamps"}, {bus.ns_r, bus.ns_a, bus.ns_g, bus.ew_r, bus.ew_a, bus.ew_g, bus.walk}, exp_lamps(s.ph));
      if (s.pw >= 0) check({tag, "_wait"}, bus.ped_wait, s.pw);
    end
  endtask
  task automatic rst_pulse(input logic pr);
    rst = 1'b1;
    bus.ped_req = pr;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    ord = '{CLR_B, NS_RA, NS_G, NS_A, CLR_A, EW_RA, EW_G, EW_A};
    bus.ped_req = 1'b0;
    fbus.ped_req = 1'b0;
    repeat (2) @(posedge clk);
    rst_pulse(1'b0);
    add_base(0); add_base(0);
    follow("base");
    rst_pulse(1'b0);
    add(CLR_B, 2, 0); add(NS_RA, 2, 0); add(NS_G, 2, 0);
    follow("pulse_pre");
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    check("pulse_wait_set", bus.ped_wait, 1);
    check("pulse_still_green", bus.phase, NS_G);
    add(NS_G, 5, 1); add(NS_A, 3, 1); add(CLR_A, 2, 1);
    add(WALK, 5, 0); add(CLR_W, 2, 0); add(EW_RA, 1, 0);
    follow("pulse");
    rst_pulse(1'b1);
    add(CLR_B, 1, 0); add(CLR_B, 1, 1); add(WALK, 5, 0); add(CLR_W, 1, 0); add(CLR_W, 1, 1);
    add(NS_RA, 2, 1); add(NS_G, 8, 1); add(NS_A, 3, 1); add(CLR_A, 2, 1);
    add(WALK, 5, 0); add(CLR_W, 1, 0); add(CLR_W, 1, 1);
    add(EW_RA, 2, 1); add(EW_G, 8, 1); add(EW_A, 3, 1); add(CLR_B, 2, 1); add(WALK, 5, 0);
    follow("held");
    bus.ped_req = 1'b0;
    rst_pulse(1'b0);
    add(CLR_B, 2, 0);
    follow("late_pre");
    bus.ped_req = 1'b1;
    add(WALK, 1, 0);
    follow("late");
    bus.ped_req = 1'b0;
    add(WALK, 4, 0); add(CLR_W, 2, 0); add(NS_RA, 2, 0); add(NS_G, 1, 0);
    follow("late");
    rst_pulse(1'b0);
    add(CLR_B, 2, 0); add(NS_RA, 2, 0); add(NS_G, 8, 0); add(NS_A, 3, 0);
    add(CLR_A, 2, 0); add(EW_RA, 2, 0); add(EW_G, 1, 0);
    follow("mid_pre");
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    check("mid_wait_set", bus.ped_wait, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_phase", bus.phase, CLR_B);
    check("mid_rst_wait", bus.ped_wait, 0);
    check("mid_rst_reds", {bus.ns_r, bus.ew_r, bus.walk}, 3'b110);
    add(CLR_B, 1, 0); add(NS_RA, 2, 0); add(NS_G, 8, 0); add(NS_A, 3, 0);
    add(CLR_A, 2, 0); add(EW_RA, 1, 0);
    follow("mid");
    @(posedge clk);
    #1 rst_f = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("fast_phase", fbus.phase, ord[i % 8]);
      check("fast_lamps", {fbus.ns_r, fbus.ns_a, fbus.ns_g, fbus.ew_r, fbus.ew_a, fbus.ew_g, fbus.walk}, exp_lamps(ord[i % 8]));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
